// File: rtl/shared_mem_sched.sv
// rtl/shared_mem_sched.sv - round-robin scheduler sharing one memory port among N cores
// Grants one core at a time, supports budgeted locked sequences and routes read data back.
module shared_mem_sched #(
  parameter int N        = 4,
  parameter int DW       = 8,
  parameter int LOCK_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_rd,
  input  logic [N-1:0]    req_wr,
  input  logic [N-1:0]    req_lock,
  input  logic [N*DW-1:0] req_wdata,
  output logic [N-1:0]    req_rdy,
  output logic [N-1:0]    req_rvalid,
  output logic [N*DW-1:0] req_rdata,
  output logic [N-1:0]    gnt,
  output logic            lock_abort,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_rdy,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GRANT  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;
  localparam logic [8:0] LMAX      = 9'(LOCK_MAX);
  localparam logic [PW-1:0] LAST   = PW'(N - 1);
  localparam logic [N-1:0] ONE     = {{(N-1){1'b0}}, 1'b1};

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [PW-1:0] gidx_q, gidx_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [7:0]    lcnt_q, lcnt_d;
  logic [N-1:0]  rv_q, rv_d;
  logic          abort_q, abort_d;

  logic [N-1:0]  act;
  logic [DW-1:0] wd [N];
  logic          granted, g_act, g_rd, g_wr, complete, rel;
  logic          pick_found;
  logic [PW-1:0] pick_idx, cand;

  assign act = req_rd | req_wr;

  for (genvar i = 0; i < N; i++) begin : g_slice
    assign wd[i] = req_wdata[i*DW +: DW];
    assign req_rdata[i*DW +: DW] = rv_q[i] ? mem_rdata : '0;
  end

  // A request with both rd and wr high is treated as a write.
  assign granted   = (state_q != ST_IDLE);
  assign g_act     = act[gidx_q];
  assign g_wr      = req_wr[gidx_q];
  assign g_rd      = req_rd[gidx_q] & ~g_wr;
  assign complete  = granted & mem_rdy;
  assign mem_rd    = granted & g_rd;
  assign mem_wr    = granted & g_wr;
  assign mem_wdata = granted ? wd[gidx_q] : '0;
  assign req_rdy   = gnt_q & {N{mem_rdy}};
  assign req_rvalid = rv_q;
  assign gnt        = gnt_q;
  assign lock_abort = abort_q;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < N; k++) begin
      cand = PW'((int'(ptr_q) + k) % N);
      if (!pick_found && act[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    lcnt_d  = lcnt_q;
    rv_d    = '0;
    abort_d = 1'b0;
    rel     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_GRANT;
          gnt_d   = ONE << pick_idx;
          gidx_d  = pick_idx;
          lcnt_d  = '0;
        end
      end
      ST_GRANT, ST_LOCKED: begin
        if (complete) begin
          if (g_rd) rv_d = ONE << gidx_q;
          if (req_lock[gidx_q] && (({1'b0, lcnt_q} + 9'd1) < LMAX)) begin
            state_d = ST_LOCKED;
            lcnt_d  = lcnt_q + 8'd1;
          end else begin
            rel     = 1'b1;
            abort_d = req_lock[gidx_q];
          end
        end else if (!g_act && (state_q == ST_GRANT || !req_lock[gidx_q])) begin
          // Abandoned grant, or an idle lock holder letting go.
          rel = 1'b1;
        end
      end
      default: rel = 1'b1;
    endcase
    if (rel) begin
      state_d = ST_IDLE;
      gnt_d   = '0;
      lcnt_d  = '0;
      ptr_d   = (gidx_q == LAST) ? '0 : gidx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      lcnt_q  <= '0;
      rv_q    <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      lcnt_q  <= lcnt_d;
      rv_q    <= rv_d;
      abort_q <= abort_d;
    end
  end

endmodule

// File: doc/shared_mem_sched.md
# shared_mem_sched

Round-robin scheduler that shares a single memory port between N requester cores. It grants one requester at a time and holds the grant until the memory returns `rdy`. It supports locked sequences (back-to-back transactions by one core, e.g. read-modify-write) bounded by a lock budget. It routes the registered read data back only to the core that issued the read. It sits between the core ports and the `mem` instance, replacing the free-standing arbiter plus mux/demux glue.

## Interface
Parameters:
- `N`, 4, number of requesters (2..8).
- `DW`, 8, data width.
- `LOCK_MAX`, 4, maximum transactions one requester may complete under a single lock (1..255).

Ports:
- `clk` in 1: clock, all state on rising edge.
- `rst_n` in 1: asynchronous reset, active-low; one clock, no other reset.
- `req_rd` in N: per-requester read request.
- `req_wr` in N: per-requester write request.
- `req_lock` in N: requester wants to keep the grant after its current transaction.
- `req_wdata` in N*DW: write data, requester i at bits [i*DW +: DW].
- `req_rdy` out N: transaction complete for requester i (combinational, `mem_rdy & gnt[i]`).
- `req_rvalid` out N: read data valid for requester i, one cycle.
- `req_rdata` out N*DW: read data; slice i is `mem_rdata` when `req_rvalid[i]`, else 0.
- `gnt` out N: registered one-hot grant (all-zero when idle).
- `lock_abort` out 1: one-cycle pulse when a lock is force-released by budget.
- `mem_rd` out 1: memory read strobe.
- `mem_wr` out 1: memory write strobe.
- `mem_wdata` out DW: memory write data.
- `mem_rdy` in 1: memory completion.
- `mem_rdata` in DW: memory read data, valid the cycle after `mem_rdy` of a read.

## Operation
- Request i is active when `req_rd[i] | req_wr[i]`. If both are high, the request is a write: `mem_rd` stays 0.
- States: IDLE (`gnt`=0), GRANT, LOCKED. Round-robin pointer `ptr` is log2(N) bits and resets to 0.
- IDLE: if any request is active, grant the first active index at or after `ptr` (wrapping modulo N) and go to GRANT. Otherwise stay in IDLE.
- GRANT/LOCKED, granted index g: `mem_rd`, `mem_wr` and `mem_wdata` are driven combinationally from requester g. In all other cases `mem_rd`=`mem_wr`=0 and `mem_wdata`=0.
- Completion is the cycle with `mem_rdy`=1 while granted.
  - If `req_lock[g]`=1 and lock count+1 < `LOCK_MAX`: go to LOCKED, keep `gnt`, increment the lock count.
  - If `req_lock[g]`=1 and lock count+1 = `LOCK_MAX`: pulse `lock_abort` next cycle and release.
  - Otherwise: release.
- Release: `gnt`←0, `ptr`←g+1 mod N, lock count←0, go to IDLE. This leaves one idle bubble between grants to different requesters or unlocked repeats.
- Abandon: requester g drops both rd and wr while granted with no `mem_rdy`. Release next edge, same as normal release with `ptr`←g+1; `req_rdy` is not issued.
- LOCKED with no active request from g: stay granted, no memory strobe, unless `req_lock[g]`=0, in which case release.
- Read return: on completion of a read, register g. `req_rvalid[g]`=1 the next cycle with `req_rdata` slice g = `mem_rdata`. All other slices are 0.
- A new requester's request during a lock is not granted until the lock releases. No starvation beyond N*`LOCK_MAX` transactions.

## Timing
- Reset (async, `rst_n`=0) drives: `gnt`=0, `ptr`=0, IDLE, lock count 0, `req_rvalid`=0, `lock_abort`=0, hence `mem_rd`=`mem_wr`=0, `mem_wdata`=0, `req_rdy`=0, `req_rdata`=0.
- Reset mid-transaction drops the grant and any pending read return. No `req_rvalid` follows.
- Request to first memory strobe: 1 cycle (IDLE→GRANT edge).
- `mem_rdy` to `req_rdy`: 0 cycles. Read `mem_rdy` to `req_rvalid`: 1 cycle.
- Unlocked throughput: 1 transaction per 2 cycles with zero-wait memory. Locked throughput: 1 per cycle.
- Pointer wrap: g=N-1 releases to `ptr`=0.

## Test plan
- Single read, N=4: core 2 asserts `req_rd`, memory `rdy` in the first grant cycle → `gnt`=4'b0100 at cycle 1, `req_rdy[2]` at cycle 1, `req_rvalid[2]` with `mem_rdata`=8'hA5 at cycle 2, `gnt`=0 at cycle 2.
- All four request writes continuously, zero-wait memory → grant order 0,1,2,3,0 with one idle cycle between each; `mem_wdata` equals each core's `req_wdata` in its grant cycle.
- Core 1 locked with 6 reads pending, `LOCK_MAX`=4, core 3 also requesting → 4 back-to-back completions for core 1, `lock_abort` pulse, then core 3 granted.
- Core 0 granted, drops request before `mem_rdy` → `gnt` to 0 next cycle, no `req_rdy[0]`, next grant goes to core 1 if it is requesting.
- `rst_n` pulsed low the cycle after a read `mem_rdy` → `req_rvalid` stays 0, all outputs return to reset values immediately, and `ptr`=0 afterwards (core 0 wins a 4-way tie).
- Core 3 asserts both `req_rd` and `req_wr` → `mem_wr`=1, `mem_rd`=0, no `req_rvalid`.
